// File: rtl/ripple_count_extender_if.sv
// Handshake and data bundle between the ripple-count consumer and its client.
// The master drives the ripple count, clear, request and ready; the slave returns snapshots.
interface ripple_count_extender_if #(
  parameter int CNT_W = 4,
  parameter int EXT_W = 8
);
  logic [CNT_W-1:0]       q_in;
  logic                   cnt_clr;
  logic                   sample_req;
  logic                   out_ready;
  logic                   out_valid;
  logic [CNT_W+EXT_W-1:0] out_count;
  logic                   out_err;
  logic                   wrap_pulse;
  logic                   ext_overflow;
  logic                   busy;

  modport master (
    output q_in, cnt_clr, sample_req, out_ready,
    input  out_valid, out_count, out_err, wrap_pulse, ext_overflow, busy
  );

  modport slave (
    input  q_in, cnt_clr, sample_req, out_ready,
    output out_valid, out_count, out_err, wrap_pulse, ext_overflow, busy
  );
endinterface

// File: rtl/ripple_count_extender.sv
// Synchronises an asynchronous ripple count, debounces it, extends it with a wrap
// counter and hands out {ext, stable} snapshots over a valid/ready handshake.
module ripple_count_extender #(
  parameter int CNT_W    = 4,
  parameter int EXT_W    = 8,
  parameter int STABLE_N = 2,
  parameter int TIMEOUT  = 15
) (
  input logic                     clk,
  input logic                     reset,
  ripple_count_extender_if.slave  bus
);

  localparam int RUN_W = $clog2(STABLE_N + 1);
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_t;

  logic [CNT_W-1:0]       s1_q, s2_q;
  logic [CNT_W-1:0]       cand_q, cand_d;
  logic [RUN_W-1:0]       run_q, run_d;
  logic [CNT_W-1:0]       stable_q, stable_d;
  logic [EXT_W-1:0]       ext_q, ext_d;
  logic                   wrap_q, wrap_d;
  logic                   ovf_q, ovf_d;
  state_t                 state_q;
  logic [TMO_W-1:0]       tmo_q;
  logic [CNT_W+EXT_W-1:0] out_count_q;
  logic                   out_err_q;
  logic                   out_valid_q;
  logic                   busy_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= bus.q_in;
      s2_q <= s1_q;
    end
  end

  // A drop of the accepted value can only come from the ripple counter wrapping.
  always_comb begin
    cand_d   = cand_q;
    run_d    = run_q;
    stable_d = stable_q;
    ext_d    = ext_q;
    wrap_d   = 1'b0;
    ovf_d    = ovf_q;
    if (bus.cnt_clr) begin
      cand_d   = '0;
      run_d    = '0;
      stable_d = '0;
      ext_d    = '0;
      ovf_d    = 1'b0;
    end else if (s2_q != cand_q) begin
      cand_d = s2_q;
      run_d  = RUN_W'(1);
    end else if (run_q == RUN_W'(STABLE_N - 1)) begin
      run_d    = RUN_W'(STABLE_N);
      stable_d = cand_q;
      if (cand_q < stable_q) begin
        ext_d  = ext_q + EXT_W'(1);
        wrap_d = 1'b1;
        if (&ext_q) begin
          ovf_d = 1'b1;
        end
      end
    end else if (run_q < RUN_W'(STABLE_N - 1)) begin
      run_d = run_q + RUN_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand_q   <= '0;
      run_q    <= '0;
      stable_q <= '0;
      ext_q    <= '0;
      wrap_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      cand_q   <= cand_d;
      run_q    <= run_d;
      stable_q <= stable_d;
      ext_q    <= ext_d;
      wrap_q   <= wrap_d;
      ovf_q    <= ovf_d;
    end
  end

  // Snapshots take ext as registered, so a wrap finishing on the latch edge is excluded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      tmo_q       <= '0;
      out_count_q <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.sample_req) begin
            state_q <= SETTLE;
            tmo_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        SETTLE: begin
          if (run_q == RUN_W'(STABLE_N) && s2_q == cand_q) begin
            out_count_q <= {ext_q, cand_q};
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
          end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
            out_count_q <= {ext_q, stable_q};
            out_err_q   <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_count    = out_count_q;
  assign bus.out_err      = out_err_q;
  assign bus.wrap_pulse   = wrap_q;
  assign bus.ext_overflow = ovf_q;
  assign bus.busy         = busy_q;

endmodule
